// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock.
// Operands are extended by one bit so the same datapath serves signed and unsigned modes.
module booth_multiplier_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH+1:0]   acc_q, acc_d;
   logic [WIDTH:0]     q_q, q_d;
   logic [WIDTH:0]     m_q, m_d;
   logic               q1_q, q1_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               done_q, done_d;

   logic [WIDTH+1:0]   m_ext;
   logic [WIDTH+1:0]   sum;
   logic [2*WIDTH+3:0] sh;
   logic               last_step;

   assign m_ext     = {m_q[WIDTH], m_q};
   assign sh        = {sum[WIDTH+1], sum, q_q};
   assign last_step = (cnt_q == LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_step) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      ready = (state_q == S_IDLE);
      busy  = (state_q == S_RUN);
   end

   // Booth add/subtract selected by the current multiplier bit pair
   always_comb begin
      unique case ({q_q[0], q1_q})
         2'b10:   sum = acc_q - m_ext;
         2'b01:   sum = acc_q + m_ext;
         default: sum = acc_q;
      endcase
   end

   // Operand load on accept, then add-and-shift each RUN cycle
   always_comb begin
      acc_d  = acc_q;
      q_d    = q_q;
      m_d    = m_q;
      q1_d   = q1_q;
      cnt_d  = cnt_q;
      prod_d = prod_q;
      done_d = 1'b0;
      if (state_q == S_IDLE && start) begin
         m_d   = is_signed ? {b[WIDTH-1], b} : {1'b0, b};
         q_d   = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
         acc_d = '0;
         q1_d  = 1'b0;
         cnt_d = '0;
      end else if (state_q == S_RUN) begin
         acc_d = sh[2*WIDTH+3:WIDTH+2];
         q_d   = sh[WIDTH+1:1];
         q1_d  = sh[0];
         cnt_d = cnt_q + CW'(1);
         if (last_step) begin
            prod_d = sh[2*WIDTH:1];
            done_d = 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         q_q    <= '0;
         m_q    <= '0;
         q1_q   <= 1'b0;
         cnt_q  <= '0;
         prod_q <= '0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         q_q    <= q_d;
         m_q    <= m_d;
         q1_q   <= q1_d;
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
         done_q <= done_d;
      end
   end

   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Testbench for booth_multiplier_seq: vector table, random ops vs arithmetic model,
// exhaustive 4-bit signed sweep and handshake/reset corner sequences.
module tb_booth_multiplier_seq;

   logic        clk;
   logic        rst_n;
   logic        start8, s8, ready8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        start4, s4, ready4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;

   int checks;
   int failures;

   booth_multiplier_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(s8),
      .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8),
      .product(p8)
   );

   booth_multiplier_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(s4),
      .a(a4), .b(b4), .ready(ready4), .busy(busy4), .done(done4),
      .product(p4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Exact integer product of two w-bit operands, truncated to 2w bits
   function automatic logic [63:0] model(input longint x, input longint y,
                                         input logic s, input int w);
      longint xa, ya, mask;
      xa = x;
      ya = y;
      if (s && xa >= (longint'(1) << (w - 1))) xa -= (longint'(1) << w);
      if (s && ya >= (longint'(1) << (w - 1))) ya -= (longint'(1) << w);
      mask = (longint'(1) << (2 * w)) - 1;
      return 64'((xa * ya) & mask);
   endfunction

   task automatic wait_ready8();
      int g;
      g = 0;
      @(negedge clk);
      while (!ready8 && g < 100) begin
         @(negedge clk);
         g++;
      end
   endtask

   // k = index of the cycle after the accept edge in which done is seen
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                       input logic is, output logic [15:0] prod,
                       output int k, output int nbusy, output int unstable);
      logic [15:0] prev;
      wait_ready8();
      a8 = ia;
      b8 = ib;
      s8 = is;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      s8 = ~is;
      k = 1;
      nbusy = 0;
      unstable = 0;
      @(negedge clk);
      prev = p8;
      while (!done8 && k < 100) begin
         if (busy8) nbusy++;
         if (p8 !== prev) unstable++;
         @(negedge clk);
         k++;
      end
      prod = p8;
   endtask

   task automatic run4(input logic [3:0] ia, input logic [3:0] ib,
                       input logic is, output logic [7:0] prod,
                       output int k);
      int g;
      g = 0;
      @(negedge clk);
      while (!ready4 && g < 100) begin
         @(negedge clk);
         g++;
      end
      a4 = ia;
      b4 = ib;
      s4 = is;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      k = 1;
      @(negedge clk);
      while (!done4 && k < 100) begin
         @(negedge clk);
         k++;
      end
      prod = p4;
   endtask

   initial begin
      vec_t        vt[11];
      logic [15:0] pr;
      logic [7:0]  pr4;
      logic [7:0]  ra, rb;
      logic        rs;
      int          k, nb, us, g, nd;

      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; s4 = 1'b0; a4 = '0; b4 = '0;

      vt[0]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
      vt[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vt[2]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      vt[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vt[4]  = '{8'h00, 8'hC8, 1'b0, 16'h0000};
      vt[5]  = '{8'h06, 8'h07, 1'b1, 16'h002A};
      vt[6]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      vt[7]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
      vt[8]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
      vt[9]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
      vt[10] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};

      repeat (2) @(negedge clk);
      chk("rst_ready", ready8, 1);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_product", p8, 0);
      chk("rst_product4", p4, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run8(vt[i].a, vt[i].b, vt[i].s, pr, k, nb, us);
         chk($sformatf("vec%0d_product", i), pr, vt[i].exp);
         chk($sformatf("vec%0d_latency", i), k, 10);
         chk($sformatf("vec%0d_busy_cycles", i), nb, 9);
         chk($sformatf("vec%0d_product_hold", i), us, 0);
      end

      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         run8(ra, rb, rs, pr, k, nb, us);
         chk($sformatf("rand%0d_%h_%h_%0d", i, ra, rb, rs), pr,
             model(longint'(ra), longint'(rb), rs, 8));
         chk($sformatf("rand%0d_latency", i), k, 10);
      end

      run4(4'h7, 4'h8, 1'b1, pr4, k);
      chk("w4_7x-8", pr4, 8'hC8);
      chk("w4_latency", k, 6);
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            run4(4'(x), 4'(y), 1'b1, pr4, k);
            chk($sformatf("w4_%0d_%0d", x, y), pr4,
                model(longint'(x), longint'(y), 1'b1, 4));
         end
      end

      // start pulsed mid-RUN with new operands is ignored
      wait_ready8();
      a8 = 8'd100; b8 = 8'd3; s8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      a8 = 8'd1; b8 = 8'd1; s8 = 1'b1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      g = 0;
      while (!done8 && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("midrun_done_seen", done8, 1);
      chk("midrun_product", p8, 16'h012C);
      @(negedge clk);
      chk("midrun_ready_after_done", ready8, 1);
      @(negedge clk);
      chk("midrun_no_extra_op", busy8, 0);
      repeat (3) @(negedge clk);
      chk("idle_product_stable", p8, 16'h012C);

      // start held high: re-accepted once ready returns
      wait_ready8();
      a8 = 8'd9; b8 = 8'hF6; s8 = 1'b1; start8 = 1'b1;
      g = 0;
      while (!busy8 && g < 50) begin
         @(negedge clk);
         g++;
      end
      g = 0;
      while (!done8 && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("held_first", p8, 16'hFFA6);
      @(negedge clk);
      chk("held_ready_after_done", ready8, 1);
      @(negedge clk);
      chk("held_second_accept", busy8, 1);
      start8 = 1'b0;
      a8 = 8'd3;
      g = 0;
      while (!done8 && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("held_second_done", done8, 1);
      chk("held_second_product", p8, 16'hFFA6);

      // reset in the middle of an operation
      wait_ready8();
      a8 = 8'd50; b8 = 8'd50; s8 = 1'b1; start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", ready8, 1);
      chk("midrst_busy", busy8, 0);
      chk("midrst_done", done8, 0);
      chk("midrst_product", p8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (15) begin
         @(negedge clk);
         if (done8) nd++;
      end
      chk("midrst_no_done", nd, 0);
      run8(8'd6, 8'd7, 1'b1, pr, k, nb, us);
      chk("after_rst_6x7", pr, 16'h002A);
      chk("after_rst_latency", k, 10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/booth_multiplier_seq.md
# booth_multiplier_seq

Parametrised, multi-cycle radix-2 Booth multiplier with a start/ready/done handshake and a per-operation signed/unsigned mode. It replaces the fixed 4x4 combinational Booth array in datapaths that need wider operands without a deep combinational carry chain. Each accepted operation retires one Booth step per clock.

## Interface

- `WIDTH`, default 8: operand width in bits. Legal values are 2 and above.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: operation request. Sampled only while `ready`=1.
- `is_signed` input, 1 bit: 1 treats `a` and `b` as two's complement; 0 treats them as unsigned. Latched on accept.
- `a` input, `WIDTH` bits: multiplier. Latched on accept.
- `b` input, `WIDTH` bits: multiplicand. Latched on accept.
- `ready` output, 1 bit: high in IDLE only. Driven combinationally from state.
- `busy` output, 1 bit: high in RUN.
- `done` output, 1 bit: registered, one-cycle pulse.
- `product` output, 2*`WIDTH` bits: result. Valid from the `done` cycle onward; held until the next accept.

## Operation

- **FSM states:** IDLE, RUN, DONE.
  - IDLE -> RUN on `start`=1.
  - RUN -> DONE after the final step.
  - DONE -> IDLE unconditionally after one cycle.
- **Accept (edge with `ready`=1 and `start`=1):**
  - Extend `a` and `b` to `WIDTH`+1 bits: sign-extend if `is_signed`=1, zero-extend otherwise.
  - Multiplicand register M = extended `b`.
  - Q = extended `a`.
  - Accumulator ACC (`WIDTH`+2 bits) = 0.
  - q_1 = 0.
  - Step counter = 0.
- **Each RUN cycle (one Booth step):**
  - {Q[0], q_1} = 10: ACC = ACC - sext(M).
  - {Q[0], q_1} = 01: ACC = ACC + sext(M).
  - 00 or 11: no add.
  - Then arithmetic-shift {ACC, Q, q_1} right by 1, replicating the ACC MSB.
  - Then increment the counter.
- **Step count:** exactly `WIDTH`+1 steps. The extra step covers the extension bit, which makes unsigned mode exact.
- **Result:** on the final step, `product` = low 2*`WIDTH` bits of the shifted {ACC, Q}.
  - This is exact for every input pair in both modes. No overflow or saturation is possible.
- **Ignored requests:** `start` in RUN or DONE is ignored. Operand and mode changes after accept do not affect the running operation.
- **Output stability:** `product` keeps its previous value during RUN and updates only on the final-step edge.

## Timing

- **Reset values** (asserted asynchronously, at any time):
  - State = IDLE, so `ready`=1.
  - `busy`=0, `done`=0, `product`=0.
  - ACC, Q, M, q_1 and the counter all = 0.
- **Reset mid-operation:** the operation is discarded and no `done` is produced. The block is ready on the first edge after `rst_n` deasserts.
- **Latency:** accept at edge E0. Steps occur at edges E1..E(`WIDTH`+1). `done`=1 and `product` valid in the cycle after E(`WIDTH`+1).
- **Ready after done:** `ready` returns high one cycle after `done`.
- **Throughput:** minimum start-to-start spacing is `WIDTH`+3 cycles.
- **`busy`:** high for exactly `WIDTH`+1 cycles per operation.
- **Back-to-back:** `start` held high continuously is accepted on every edge where `ready`=1. No request is lost while held.

## Test plan

- **Signed, negative result:** `WIDTH`=8, `is_signed`=1, a=-3, b=5 -> `product`=16'hFFF1. `done` arrives exactly 10 cycles after the accept edge.
- **Signed, most-negative operands:** `WIDTH`=8, `is_signed`=1, a=-128, b=-128 -> 16'h4000. Also a=-128, b=127 -> 16'hC080.
- **Unsigned mode:** `WIDTH`=8, `is_signed`=0, a=255, b=255 -> 16'hFE01. Also a=0, b=200 -> 16'h0000.
- **Legacy 4x4 equivalence:** `WIDTH`=4, `is_signed`=1, exhaustively sweep all 256 (a, b) pairs. `product` equals the 8-bit signed product, e.g. 7 x -8 -> 8'hC8.
- **Handshake:**
  - Pulse `start` mid-RUN with new operands -> ignored; the first result is unchanged.
  - `start` held high -> a second accept occurs one cycle after `done`.
  - `product` stays stable between operations.
- **Reset mid-operation:** `WIDTH`=8, assert `rst_n`=0 at step 4 -> all outputs return to reset values immediately and no `done` appears. A new op (6 x 7) then returns 16'h002A.
